// File: rtl/ir_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ir_prefetch_queue
// Brief    : Instruction register fed by a DEPTH-entry prefetch FIFO with
//            same-edge bypass, branch flush and valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module ir_prefetch_queue #(
   parameter int                DATA_W = 32,
   parameter int                DEPTH  = 4,
   parameter logic [DATA_W-1:0] NOP    = '0
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     Flush,
   input  logic                     InValid,
   input  logic [DATA_W-1:0]        InData,
   output logic                     InReady,
   input  logic                     IRWre,
   output logic [DATA_W-1:0]        IR_Out,
   output logic                     IRValid,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int                c_AW       = $clog2(DEPTH);
   localparam logic [c_AW-1:0]   c_PTR_ONE  = {{(c_AW-1){1'b0}}, 1'b1};
   localparam logic [c_AW:0]     c_CNT_ONE  = {{c_AW{1'b0}}, 1'b1};
   localparam logic [c_AW:0]     c_CNT_FULL = (c_AW+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW:0]     r_count;
   logic [DATA_W-1:0] r_ir;
   logic              r_ir_valid;

   logic w_empty;
   logic w_push;
   logic w_pop_mem;
   logic w_bypass;
   logic w_wr_mem;

   assign w_empty   = (r_count == '0);
   assign InReady   = (r_count != c_CNT_FULL) && !Flush;
   assign w_push    = InValid && InReady;
   assign w_pop_mem = IRWre && !w_empty;
   assign w_bypass  = IRWre && w_empty && w_push;
   // A bypassed word goes straight to the IR and never occupies storage.
   assign w_wr_mem  = w_push && !w_bypass;

   always_ff @(negedge CLK) begin
      if (w_wr_mem) begin
         r_mem[r_wr_ptr] <= InData;
      end
   end

   always_ff @(negedge CLK or posedge Reset) begin
      if (Reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_ir       <= NOP;
         r_ir_valid <= 1'b0;
      end else if (Flush) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_ir       <= NOP;
         r_ir_valid <= 1'b0;
      end else begin
         if (w_wr_mem) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop_mem) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_wr_mem && !w_pop_mem) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_pop_mem && !w_wr_mem) begin
            r_count <= r_count - c_CNT_ONE;
         end
         if (IRWre) begin
            if (w_pop_mem) begin
               r_ir       <= r_mem[r_rd_ptr];
               r_ir_valid <= 1'b1;
            end else if (w_bypass) begin
               r_ir       <= InData;
               r_ir_valid <= 1'b1;
            end else begin
               // Underflow: keep the stale word but mark it invalid.
               r_ir_valid <= 1'b0;
            end
         end
      end
   end

   assign IR_Out  = r_ir;
   assign IRValid = r_ir_valid;
   assign Count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ir_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_prefetch_queue
// Brief    : Directed and random stimulus for ir_prefetch_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_prefetch_queue;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic              CLK;
   logic              Reset;
   logic              Flush;
   logic              InValid;
   logic [DATA_W-1:0] InData;
   logic              InReady;
   logic              IRWre;
   logic [DATA_W-1:0] IR_Out;
   logic              IRValid;
   logic [2:0]        Count;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] m_q [$];
   logic [DATA_W-1:0] m_ir;
   logic              m_valid;

   ir_prefetch_queue #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NOP    (32'h00000000)
   ) u_dut (
      .CLK     (CLK),
      .Reset   (Reset),
      .Flush   (Flush),
      .InValid (InValid),
      .InData  (InData),
      .InReady (InReady),
      .IRWre   (IRWre),
      .IR_Out  (IR_Out),
      .IRValid (IRValid),
      .Count   (Count)
   );

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ir    = 32'h0;
      m_valid = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".IR_Out"},  IR_Out, m_ir);
      chk({tag, ".IRValid"}, {31'd0, IRValid}, {31'd0, m_valid});
      chk({tag, ".Count"},   {29'd0, Count}, m_q.size());
   endtask

   // Called just after a rising edge; the DUT acts on the following falling edge.
   task automatic step(input string tag, input logic inv, input logic [31:0] d,
                       input logic irw, input logic fl);
      logic ready;
      logic push;
      InValid = inv;
      InData  = d;
      IRWre   = irw;
      Flush   = fl;
      ready   = (m_q.size() != DEPTH) && !fl;
      push    = inv && ready;
      #1;
      chk({tag, ".InReady"}, {31'd0, InReady}, {31'd0, ready});
      @(negedge CLK);
      if (fl) begin
         model_reset();
      end else if (irw) begin
         if (m_q.size() > 0) begin
            m_ir    = m_q.pop_front();
            m_valid = 1'b1;
            if (push) m_q.push_back(d);
         end else if (push) begin
            m_ir    = d;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end else if (push) begin
         m_q.push_back(d);
      end
      @(posedge CLK);
      check_state(tag);
   endtask

   initial begin
      Reset   = 1'b0;
      Flush   = 1'b0;
      InValid = 1'b0;
      InData  = '0;
      IRWre   = 1'b0;
      model_reset();
      #1 Reset = 1'b1;
      #2;
      check_state("por");
      @(posedge CLK);
      Reset = 1'b0;

      // Reset mid-stream with Count=3 and a valid IR
      for (int i = 0; i < 4; i++) step("pre_rst_push", 1'b1, 32'hC0DE0000 + i, 1'b0, 1'b0);
      step("pre_rst_pop", 1'b0, '0, 1'b1, 1'b0);
      chk("pre_rst.Count",   {29'd0, Count}, 32'd3);
      chk("pre_rst.IRValid", {31'd0, IRValid}, 32'd1);
      #1 Reset = 1'b1;
      model_reset();
      #1;
      check_state("mid_rst");
      Reset = 1'b0;
      #1;
      chk("mid_rst.InReady", {31'd0, InReady}, 32'd1);

      // In-order delivery
      step("push1", 1'b1, 32'h11111111, 1'b0, 1'b0);
      step("push2", 1'b1, 32'h22222222, 1'b0, 1'b0);
      step("push3", 1'b1, 32'h33333333, 1'b0, 1'b0);
      step("pop1", 1'b0, '0, 1'b1, 1'b0);
      chk("pop1.word", IR_Out, 32'h11111111);
      step("pop2", 1'b0, '0, 1'b1, 1'b0);
      chk("pop2.word", IR_Out, 32'h22222222);
      step("pop3", 1'b0, '0, 1'b1, 1'b0);
      chk("pop3.word", IR_Out, 32'h33333333);
      chk("pop3.Count", {29'd0, Count}, 32'd0);

      // Full queue: push is refused while a pop happens
      for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'hF0000000 + i, 1'b0, 1'b0);
      chk("full.Count", {29'd0, Count}, 32'd4);
      step("full_pushpop", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      chk("full_pushpop.Count", {29'd0, Count}, 32'd3);
      step("after_full_push", 1'b1, 32'hF0000004, 1'b0, 1'b0);
      chk("after_full_push.Count", {29'd0, Count}, 32'd4);
      for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

      // Bypass then underflow
      step("bypass", 1'b1, 32'hABCD0001, 1'b1, 1'b0);
      chk("bypass.word", IR_Out, 32'hABCD0001);
      step("underflow", 1'b0, '0, 1'b1, 1'b0);
      chk("underflow.word", IR_Out, 32'hABCD0001);
      chk("underflow.IRValid", {31'd0, IRValid}, 32'd0);

      // Flush with Count=2, then pointer wrap
      step("pre_flush1", 1'b1, 32'h0000AAAA, 1'b1, 1'b0);
      step("pre_flush2", 1'b1, 32'h0000BBBB, 1'b0, 1'b0);
      step("pre_flush3", 1'b1, 32'h0000CCCC, 1'b0, 1'b0);
      step("flush", 1'b1, 32'h0000DDDD, 1'b0, 1'b1);
      chk("flush.word", IR_Out, 32'h0);
      for (int i = 0; i < 8; i++) begin
         step("wrap_push", 1'b1, 32'h50000000 + i, 1'b0, 1'b0);
         step("wrap_push", 1'b1, 32'h60000000 + i, 1'b0, 1'b0);
         step("wrap_pop",  1'b0, '0, 1'b1, 1'b0);
         step("wrap_pop",  1'b0, '0, 1'b1, 1'b0);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 9) < 6), $urandom, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 31) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
